// File: rtl/mls_axis_mapper.sv
// mls_axis_mapper: maps LFSR sequence bits to saturated 14-bit DAC codes on an AXI-Stream master.
// Optional MLS_AXIS_MAPPER_STATUS_EN adds sample_cnt_o and stall_o.
module mls_axis_mapper #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  periods_i,
  input  logic [13:0]       amp_i,
  input  logic [13:0]       offset_i,
  input  logic              sig_i,
  input  logic              flag_i,
  output logic              lfsr_en_o,
  output logic              lfsr_srst_o,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy_o,
  output logic              done_o
`ifdef MLS_AXIS_MAPPER_STATUS_EN
  ,
  output logic [31:0]       sample_cnt_o,
  output logic              stall_o
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_periods, r_cnt;
  logic [13:0]        r_amp, r_off, r_data;
  logic               r_valid, r_last, r_done;
  logic signed [14:0] w_amp, w_off, w_sum;
  logic [13:0]        w_sat;
  logic               w_en, w_final;
  assign w_amp = {r_amp[13], r_amp};
  assign w_off = {r_off[13], r_off};
  // 15 bits hold offset +/- amp for every 14-bit input, including -(-8192)
  assign w_sum = w_off + (sig_i ? w_amp : -w_amp);
  assign w_sat = (w_sum > 15'sd8191) ? 14'h1fff : (w_sum < -15'sd8192) ? 14'h2000 : w_sum[13:0];
  assign w_en = (r_state == RUN) && (!r_valid || m_axis_tready);
  assign w_final = flag_i && (r_periods != '0) && (CNT_W'(r_cnt + 1'b1) == r_periods);
  assign lfsr_en_o = w_en;
  assign lfsr_srst_o = (r_state == IDLE) || (r_state == LOAD);
  assign m_axis_tdata = {{(DATA_W-14){r_data[13]}}, r_data};
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast = r_last;
  assign busy_o = r_state != IDLE;
  assign done_o = r_done;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_periods <= '0;
      r_cnt <= '0;
      r_amp <= '0;
      r_off <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start_i) r_state <= LOAD;
          LOAD: begin
            r_periods <= periods_i;
            r_amp <= amp_i;
            r_off <= offset_i;
            r_cnt <= '0;
            r_state <= RUN;
          end
          RUN: if (w_en) begin
            r_data <= w_sat;
            r_last <= flag_i;
            r_valid <= 1'b1;
            if (flag_i) r_cnt <= r_cnt + 1'b1;
            if (w_final) r_state <= DRAIN;
          end
          default: if (!r_valid || m_axis_tready) begin
            r_valid <= 1'b0;
            r_last <= 1'b0;
            r_done <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
`ifdef MLS_AXIS_MAPPER_STATUS_EN
  logic [31:0] r_scnt;
  assign sample_cnt_o = r_scnt;
  assign stall_o = (r_state == RUN) && r_valid && !m_axis_tready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_scnt <= '0;
    else if (r_state == LOAD && !abort_i) r_scnt <= '0;
    else if (r_valid && m_axis_tready && r_scnt != '1) r_scnt <= r_scnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mls_axis_mapper.sv
// tb_mls_axis_mapper: randomized bench with a 63-bit generator fixture and a sequence-level reference model.
module tb_mls_axis_mapper;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [15:0] periods_i = '0;
  logic [13:0] amp_i = '0, offset_i = '0;
  logic        sig_i, flag_i;
  logic        lfsr_en_o, lfsr_srst_o;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, busy_o, done_o;
  logic        m_axis_tready = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic [5:0]  g = 6'd1;
  bit          s [0:68];

  always #5 clk = ~clk;

  mls_axis_mapper dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i),
    .periods_i(periods_i), .amp_i(amp_i), .offset_i(offset_i),
    .sig_i(sig_i), .flag_i(flag_i), .lfsr_en_o(lfsr_en_o), .lfsr_srst_o(lfsr_srst_o),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy_o(busy_o), .done_o(done_o)
  );

  // generator fixture: x^6+x+1 Fibonacci LFSR, flag on the state before the seed recurs
  logic [5:0] g_nxt;
  assign g_nxt = {g[0] ^ g[1], g[5:1]};
  assign sig_i = g[0];
  assign flag_i = g_nxt == 6'd1;
  always @(posedge clk) g <= lfsr_srst_o ? 6'd1 : lfsr_en_o ? g_nxt : g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] code(input bit b, input int amp, input int off);
    int v = off + (b ? amp : -amp);
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v[15:0];
  endfunction

  task automatic run(input int per, input int amp, input int off, input int p, input int abort_at);
    int beat = 0, cyc = 0;
    bit fin = 0, pst = 0, mid = 0;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    @(negedge clk);
    periods_i = 16'(per); amp_i = 14'(amp); offset_i = 14'(off); start_i = 1'b1; m_axis_tready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    forever begin
      @(negedge clk);
      start_i = 1'b0;
      m_axis_tready = ($urandom_range(0, 99) < p);
      #1;
      if (fin) begin
        chk("done", done_o, 1);
        chk("busy_after", busy_o, 0);
        chk("tvalid_after", m_axis_tvalid, 0);
        break;
      end
      chk("done_early", done_o, 0);
      if (pst) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", m_axis_tdata, pd);
        chk("hold_last", m_axis_tlast, pl);
      end
      if (abort_at >= 0 && beat == abort_at) begin
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_srst", lfsr_srst_o, 1);
        chk("abort_done", done_o, 0);
        break;
      end
      if (m_axis_tvalid && !m_axis_tready) chk("stall_en", lfsr_en_o, 0);
      pst = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        chk($sformatf("data%0d", beat), m_axis_tdata, code(s[beat % 63], amp, off));
        chk($sformatf("last%0d", beat), m_axis_tlast, (beat % 63) == 62);
        beat++;
        if (per != 0 && beat == per * 63) fin = 1;
      end
      if (beat == 10 && !mid) begin
        start_i = 1'b1;
        amp_i = 14'(amp ^ 14'h155);
        offset_i = 14'(off + 77);
        periods_i = 16'(per + 1);
        mid = 1;
      end
      if (++cyc > 3000) begin
        chk("timeout", 0, 1);
        break;
      end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) s[i] = (i == 0);
    for (int i = 0; i < 63; i++) s[i+6] = s[i] ^ s[i+1];
    repeat (3) @(negedge clk);
    chk("rst_srst", lfsr_srst_o, 1);
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_en", lfsr_en_o, 0);
    rstn = 1'b1;
    run(2, 1000, 0, 100, -1);
    run(2, 1000, 0, 50, -1);
    run(1, 1000, 8000, 60, -1);
    run(1, 1000, -8000, 100, -1);
    run(1, -8192, 0, 70, -1);
    run(1, $urandom_range(0, 8191), int'($urandom_range(0, 8000)) - 4000, 50, -1);
    run(0, 1234, 100, 100, 40);
    run(1, 1234, 100, 80, -1);
    // async reset in the middle of a stalled RUN
    @(negedge clk);
    periods_i = 16'd0; amp_i = 14'd500; offset_i = 14'd0; start_i = 1'b1; m_axis_tready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", m_axis_tvalid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", m_axis_tvalid, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_srst", lfsr_srst_o, 1);
    chk("arst_data", m_axis_tdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    run(1, 2000, -100, 50, -1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
